// File: rtl/uart_cmd_rx_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx_if
//   Bundles the serial input and the command-level outputs of uart_cmd_rx.
//   Signals:
//     rx         1  raw serial line, idle high, asynchronous to clk
//     cmd        8  command level presented to the stats block (8'h00 = none)
//     cmd_valid  1  1-cycle pulse when a new byte first appears on cmd
//     frame_err  1  1-cycle pulse when a stop bit samples low
//     busy       1  high while the receive FSM is not idle
//   Modports:
//     master  drives rx, observes the command outputs (host / bench side)
//     slave   receives rx, drives the command outputs (uart_cmd_rx side)
// -----------------------------------------------------------------------------
interface uart_cmd_rx_if;
    logic       rx;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  cmd,
        input  cmd_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output cmd,
        output cmd_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
//   8N1 UART receiver that turns serial commands into an 8-bit command level.
//   Each accepted byte is held on cmd for HOLD_CYCLES clocks and then cleared
//   to 8'h00 so the consumer re-arms. A byte arriving while cmd is nonzero is
//   parked in a 1-entry pending register and presented after a forced 1-cycle
//   8'h00 gap. Received 8'h00 bytes are dropped silently.
//
//   Build option:
//     CMD_FILTER_EN  when defined, only 'e' (8'h65), 's' (8'h73), 'h' (8'h68)
//                    and 'l' (8'h6c) are accepted; other well-framed bytes are
//                    dropped without any pulse. Undefined: every nonzero byte
//                    with a valid stop bit is accepted.
//
//   Parameters:
//     CLK_HZ       system clock in Hz
//     BAUD         serial bit rate; CLKS_PER_BIT = CLK_HZ / BAUD
//     HOLD_CYCLES  clocks a command stays on cmd before auto-clear (>= 1)
//
//   Ports:
//     clk      in   system clock, rising edge
//     reset_n  in   asynchronous active-low reset
//     bus      uart_cmd_rx_if.slave (rx in; cmd, cmd_valid, frame_err, busy out)
// -----------------------------------------------------------------------------
module uart_cmd_rx #(
    parameter int CLK_HZ      = 27000000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    uart_cmd_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HOLD_W       = $clog2(HOLD_CYCLES + 1);

    localparam logic [BAUD_W-1:0] HALF_CNT  = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BAUD_W-1:0] LAST_CNT  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Receive path state
    logic [1:0]        sync_reg;
    logic              rx_prev_reg;
    logic [1:0]        state_reg,    state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_idx_reg,  bit_idx_next;
    logic [7:0]        shift_reg,    shift_next;

    // Output stage state
    logic [7:0]        cmd_reg,        cmd_next;
    logic              cmd_valid_reg,  cmd_valid_next;
    logic              frame_err_reg,  frame_err_next;
    logic [HOLD_W-1:0] hold_cnt_reg,   hold_cnt_next;
    logic [7:0]        pend_reg,       pend_next;
    logic              pend_valid_reg, pend_valid_next;

    logic rx_s;
    logic fall_edge;
    logic stop_ok;
    logic stop_bad;
    logic byte_ok;
    logic accept;

    assign rx_s      = sync_reg[1];
    assign fall_edge = rx_prev_reg & ~rx_s;

    // Command filter
`ifdef CMD_FILTER_EN
    localparam logic [31:0] ALLOWED_CODES = {8'h6c, 8'h68, 8'h73, 8'h65};
    logic [3:0] code_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_code
            assign code_hit[gi] = (shift_reg == ALLOWED_CODES[gi*8 +: 8]);
        end
    endgenerate

    assign byte_ok = |code_hit;
`else
    assign byte_ok = (shift_reg != 8'h00);
`endif

    // A zero byte is never presented, whatever the filter says.
    assign accept = stop_ok & byte_ok & (shift_reg != 8'h00);

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
        // Saturating count; every state that uses it resets it explicitly.
        if (baud_cnt_reg == LAST_CNT) begin
            baud_cnt_next = baud_cnt_reg;
        end else begin
            baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
        end

        unique case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                if (fall_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // Mid start bit: a high sample means the edge was a glitch.
                if (baud_cnt_reg == HALF_CNT) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    state_next    = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                // Sample point is now a whole bit period after mid start.
                if (baud_cnt_reg == LAST_CNT) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_s, shift_reg[7:1]};
                    bit_idx_next  = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Return to idle at mid-stop so a new start edge can follow
                // without waiting for the end of the stop bit.
                if (baud_cnt_reg == LAST_CNT) begin
                    baud_cnt_next = '0;
                    state_next    = ST_IDLE;
                    stop_ok       = rx_s;
                    stop_bad      = ~rx_s;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                baud_cnt_next = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output stage: hold timer, pending slot and 1-cycle gap
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_next        = cmd_reg;
        cmd_valid_next  = 1'b0;
        frame_err_next  = stop_bad;
        hold_cnt_next   = hold_cnt_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;

        if (accept) begin
            if (cmd_reg == 8'h00) begin
                // Free output (including the gap cycle): present directly.
                // A byte still pending is superseded, so the newest wins.
                cmd_next        = shift_reg;
                cmd_valid_next  = 1'b1;
                hold_cnt_next   = HOLD_LOAD;
                pend_valid_next = 1'b0;
            end else begin
                // Output busy (also when the hold expires this very cycle):
                // park the byte and force one cycle of 8'h00.
                pend_next       = shift_reg;
                pend_valid_next = 1'b1;
                cmd_next        = 8'h00;
                hold_cnt_next   = '0;
            end
        end else if (pend_valid_reg) begin
            cmd_next        = pend_reg;
            cmd_valid_next  = 1'b1;
            hold_cnt_next   = HOLD_LOAD;
            pend_valid_next = 1'b0;
        end else if (cmd_reg != 8'h00) begin
            // The counter is loaded with HOLD_CYCLES on the first cmd cycle;
            // clearing as it steps to zero keeps the byte up for exactly
            // HOLD_CYCLES clocks and the counter never wraps.
            if (hold_cnt_reg <= HOLD_W'(1)) begin
                cmd_next      = 8'h00;
                hold_cnt_next = '0;
            end else begin
                hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg       <= 2'b11;
            rx_prev_reg    <= 1'b1;
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            cmd_reg        <= 8'h00;
            cmd_valid_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
            hold_cnt_reg   <= '0;
            pend_reg       <= 8'h00;
            pend_valid_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[0], bus.rx};
            rx_prev_reg    <= rx_s;
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            cmd_reg        <= cmd_next;
            cmd_valid_reg  <= cmd_valid_next;
            frame_err_reg  <= frame_err_next;
            hold_cnt_reg   <= hold_cnt_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

    assign bus.cmd       = cmd_reg;
    assign bus.cmd_valid = cmd_valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
//   Directed bench for uart_cmd_rx at 10 clocks per bit. dut_a uses
//   HOLD_CYCLES=16; dut_b shares the same serial line with HOLD_CYCLES=200 so a
//   second frame lands while its first command is still held (gap behaviour).
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;

    localparam int SIM_CLK_HZ = 1000000;
    localparam int SIM_BAUD   = 100000;
    localparam int BIT_CLKS   = 10;
    localparam int HOLD_A     = 16;
    localparam int HOLD_B     = 200;

`ifdef CMD_FILTER_EN
    localparam logic [7:0] EXP_41 = 8'h00;
    localparam logic       EXP_41_VALID = 1'b0;
`else
    localparam logic [7:0] EXP_41 = 8'h41;
    localparam logic       EXP_41_VALID = 1'b1;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx_line = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk = ~clk;

    uart_cmd_rx_if bus_a ();
    uart_cmd_rx_if bus_b ();

    assign bus_a.rx = rx_line;
    assign bus_b.rx = rx_line;

    uart_cmd_rx #(.CLK_HZ(SIM_CLK_HZ), .BAUD(SIM_BAUD), .HOLD_CYCLES(HOLD_A)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    uart_cmd_rx #(.CLK_HZ(SIM_CLK_HZ), .BAUD(SIM_BAUD), .HOLD_CYCLES(HOLD_B)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    // Advance n clocks; leaves us 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start + 8 data bits + stop value and returns in the cycle in
    // which the receiver samples the stop bit (8 clocks into the stop bit,
    // given the 2-clock synchronizer and 1-clock edge detect).
    task automatic send_to_stop(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            tick(BIT_CLKS);
        end
        rx_line = stop_bit;
        tick(8);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_line = 1'b1;
        tick(3);
        total++; if (bus_a.cmd !== 8'h00) begin bad++; $display("FAIL rst_cmd got=%h want=00", bus_a.cmd); end
        total++; if (bus_a.cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus_a.cmd_valid); end
        total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b want=0", bus_a.frame_err); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus_a.busy); end
        reset_n = 1'b1;
        tick(5);
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b want=0", bus_a.busy); end
        $display("test_reset: cmd=%h busy=%b", bus_a.cmd, bus_a.busy);
    endtask

    task automatic test_single();
        send_to_stop(8'h65, 1'b1);
        total++; if (bus_a.cmd_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", bus_a.cmd_valid); end
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus_a.busy); end
        tick(1);
        total++; if (bus_a.cmd !== 8'h65) begin bad++; $display("FAIL single_cmd got=%h want=65", bus_a.cmd); end
        total++; if (bus_a.cmd_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus_a.cmd_valid); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop got=%b want=0", bus_a.busy); end
        total++; if (bus_b.cmd !== 8'h65) begin bad++; $display("FAIL single_cmd_b got=%h want=65", bus_b.cmd); end
        tick(1);
        total++; if (bus_a.cmd_valid !== 1'b0) begin bad++; $display("FAIL single_valid_pulse got=%b want=0", bus_a.cmd_valid); end
        tick(14);
        total++; if (bus_a.cmd !== 8'h65) begin bad++; $display("FAIL single_hold_last got=%h want=65", bus_a.cmd); end
        tick(1);
        total++; if (bus_a.cmd !== 8'h00) begin bad++; $display("FAIL single_clear got=%h want=00", bus_a.cmd); end
        $display("test_single: byte 65 presented and cleared after %0d clks", HOLD_A);
    endtask

    task automatic test_back_to_back();
        tick(HOLD_B);
        send_to_stop(8'h73, 1'b1);
        tick(1);
        total++; if (bus_b.cmd !== 8'h73) begin bad++; $display("FAIL b2b_first got=%h want=73", bus_b.cmd); end
        tick(1);
        send_to_stop(8'h68, 1'b1);
        total++; if (bus_b.cmd !== 8'h73) begin bad++; $display("FAIL b2b_still_held got=%h want=73", bus_b.cmd); end
        tick(1);
        total++; if (bus_b.cmd !== 8'h00) begin bad++; $display("FAIL b2b_gap got=%h want=00", bus_b.cmd); end
        total++; if (bus_b.cmd_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap_valid got=%b want=0", bus_b.cmd_valid); end
        total++; if (bus_a.cmd !== 8'h68) begin bad++; $display("FAIL b2b_nogap_a got=%h want=68", bus_a.cmd); end
        total++; if (bus_a.cmd_valid !== 1'b1) begin bad++; $display("FAIL b2b_nogap_valid_a got=%b want=1", bus_a.cmd_valid); end
        tick(1);
        total++; if (bus_b.cmd !== 8'h68) begin bad++; $display("FAIL b2b_second got=%h want=68", bus_b.cmd); end
        total++; if (bus_b.cmd_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", bus_b.cmd_valid); end
        tick(1);
        total++; if (bus_b.cmd_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_pulse got=%b want=0", bus_b.cmd_valid); end
        total++; if (bus_b.cmd !== 8'h68) begin bad++; $display("FAIL b2b_second_hold got=%h want=68", bus_b.cmd); end
        $display("test_back_to_back: 73 then 68 with 1-clk gap on long-hold instance");
    endtask

    task automatic test_frame_err();
        tick(20);
        send_to_stop(8'h6c, 1'b0);
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL ferr_busy got=%b want=1", bus_a.busy); end
        tick(1);
        total++; if (bus_a.frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b want=1", bus_a.frame_err); end
        total++; if (bus_a.cmd !== 8'h00) begin bad++; $display("FAIL ferr_cmd got=%h want=00", bus_a.cmd); end
        total++; if (bus_a.cmd_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%b want=0", bus_a.cmd_valid); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_drop got=%b want=0", bus_a.busy); end
        tick(1);
        total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL ferr_pulse_width got=%b want=0", bus_a.frame_err); end
        rx_line = 1'b1;
        tick(20);
        $display("test_frame_err: 6c with low stop bit flagged");
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        rx_line = 1'b0;
        tick(3);
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL glitch_start got=%b want=1", bus_a.busy); end
        rx_line = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus_a.cmd_valid || bus_a.frame_err) pulses++;
        end
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL glitch_before_sample got=%b want=1", bus_a.busy); end
        tick(1);
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL glitch_reject got=%b want=0", bus_a.busy); end
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus_a.cmd_valid || bus_a.frame_err) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pulses); end
        total++; if (bus_a.cmd !== 8'h00) begin bad++; $display("FAIL glitch_cmd got=%h want=00", bus_a.cmd); end
        $display("test_glitch: 3-clk low pulse rejected");
    endtask

    task automatic test_filter();
        tick(10);
        send_to_stop(8'h41, 1'b1);
        tick(1);
        total++; if (bus_a.cmd !== EXP_41) begin bad++; $display("FAIL filt_cmd got=%h want=%h", bus_a.cmd, EXP_41); end
        total++; if (bus_a.cmd_valid !== EXP_41_VALID) begin bad++; $display("FAIL filt_valid got=%b want=%b", bus_a.cmd_valid, EXP_41_VALID); end
        total++; if (bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL filt_ferr got=%b want=0", bus_a.frame_err); end
        tick(15);
        total++; if (bus_a.cmd !== EXP_41) begin bad++; $display("FAIL filt_hold got=%h want=%h", bus_a.cmd, EXP_41); end
        tick(1);
        total++; if (bus_a.cmd !== 8'h00) begin bad++; $display("FAIL filt_clear got=%h want=00", bus_a.cmd); end
        $display("test_filter: byte 41 -> cmd %h", EXP_41);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h65;
        tick(10);
        rx_line = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx_line = b[i];
            tick(BIT_CLKS);
        end
        rx_line = b[3];
        tick(4);
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", bus_a.busy); end
        reset_n = 1'b0;
        rx_line = 1'b1;
        #1;
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus_a.busy); end
        total++; if (bus_b.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_b got=%b want=0", bus_b.busy); end
        total++; if (bus_b.cmd !== 8'h00) begin bad++; $display("FAIL midrst_cmd_b got=%h want=00", bus_b.cmd); end
        total++; if (bus_a.cmd_valid !== 1'b0 || bus_a.frame_err !== 1'b0) begin bad++; $display("FAIL midrst_pulses got=%b%b want=00", bus_a.cmd_valid, bus_a.frame_err); end
        tick(2);
        reset_n = 1'b1;
        tick(5);
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b want=0", bus_a.busy); end
        send_to_stop(8'h65, 1'b1);
        tick(1);
        total++; if (bus_a.cmd !== 8'h65) begin bad++; $display("FAIL midrst_recover got=%h want=65", bus_a.cmd); end
        total++; if (bus_a.cmd_valid !== 1'b1) begin bad++; $display("FAIL midrst_recover_valid got=%b want=1", bus_a.cmd_valid); end
        tick(20);
        $display("test_reset_mid_frame: frame abandoned, next 65 received");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_filter();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
